mult_arbiter: RTL
=================

MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; product width is 2*WIDTH.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 req0, req1  input  1 each  operation request from requester 0 / 1; held high until acknowledged.
REQ-005 a0, b0, a1, b1  input  WIDTH each  signed multiplicand / multiplier per requester; stable while req high.
REQ-006 ack0, ack1  output  1 each  one-cycle pulse: request and operands accepted.
REQ-007 res0, res1  output  2*WIDTH each  last signed product delivered to that requester.
REQ-008 vld0, vld1  output  1 each  one-cycle pulse: corresponding res updated.
REQ-009 busy  output  1  high whenever the FSM is not in IDLE.
REQ-010 mul_start  output  1  start strobe to the shared Booth multiplier.
REQ-011 mul_x, mul_y  output  WIDTH each  operands to the multiplier; held stable from ISSUE until the end of WAIT.
REQ-012 mul_ready, mul_done  input  1 each  multiplier idle flag / one-cycle completion pulse.
REQ-013 mul_p  input  2*WIDTH  multiplier product, valid in the cycle mul_done is high.

Function
REQ-014 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-015 IDLE: when mul_ready=1 and at least one req high, select a winner, latch its operands into mul_x/mul_y, pulse its ack, record the owner, go to ISSUE; otherwise stay.
REQ-016 ISSUE: assert mul_start for exactly one cycle, go to WAIT.
REQ-017 WAIT: on mul_done=1, capture mul_p into the owner's res register, go to RESP; otherwise stay, no timeout.
REQ-018 RESP: pulse the owner's vld for one cycle, go to IDLE.
REQ-019 Latency: the ack cycle precedes the mul_start cycle by 1; vld follows the mul_done cycle by 1.
REQ-020 Requests SHALL be sampled only in IDLE; req changes in other states are ignored.
REQ-021 mul_done in IDLE, ISSUE or RESP SHALL be ignored (no res or vld change).
REQ-022 res of the non-owning requester SHALL hold its value across the whole operation.
REQ-023 At most one ack and at most one vld SHALL be high in any cycle.
REQ-024 mul_ready=0 in IDLE SHALL block grants; requests remain pending.
REQ-025 A requester keeping req high after its ack SHALL be treated as a new request at the next IDLE.
REQ-026 mul_x and mul_y SHALL change only in the IDLE grant cycle.

Reset
REQ-027 While rst=0: FSM in IDLE; ack0, ack1, vld0, vld1, mul_start and busy are 0; res0, res1, mul_x and mul_y are 0; the last-winner register points to requester 1.
REQ-028 Reset asserted mid-operation SHALL abandon the operation with no vld pulse; the first grant after release follows REQ-027 state.

Configuration
REQ-029 Macro MULT_ARB_RR_EN defined: round-robin arbitration; on simultaneous requests, the requester not granted last wins; the last-winner register updates at each grant.
REQ-030 Macro MULT_ARB_RR_EN undefined: fixed priority, requester 0 always wins ties; the last-winner register is not implemented.

Verification
REQ-031 Single request: WIDTH=8, req0=1, a0=3, b0=-2 -> ack0 pulse, mul_start 1 cycle later, vld0 1 cycle after mul_done, res0=16'hFFFA, res1 unchanged.
REQ-032 Simultaneous req0 and req1 held high, with RR_EN defined, out of reset -> grant order 0,1,0,1; without the macro -> 0,0,0.
REQ-033 req1=1 while the FSM is in WAIT for requester 0 -> no ack1 until RESP completes; ack1 arrives in the first IDLE cycle after it.
REQ-034 mul_ready=0 with req0=1 for 5 cycles -> no ack0 and busy=0; mul_ready rises -> ack0 in that same cycle.
REQ-035 rst driven low during WAIT -> all outputs 0 immediately (asynchronous); no vld after release; a subsequent req completes normally.
REQ-036 Spurious mul_done pulse in IDLE -> res0 and res1 unchanged, no vld pulse.

Source files
------------

// File: rtl/mult_arbiter.sv
// -----------------------------------------------------------------------------
// mult_arbiter
//   Arbitrates two requesters onto one shared Booth multiplier. A winner's
//   operands are latched and presented to the multiplier, one start strobe is
//   issued, the product is captured into the winner's result register on
//   completion, and a one-cycle valid pulse is returned to that requester.
//
// Configuration macro:
//   MULT_ARB_RR_EN  defined   : round-robin arbitration. On a tie, the
//                               requester not granted last wins.
//                   undefined : fixed priority. Requester 0 wins ties.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active low
//   req0/req1  in   request, held high until ack
//   a0,b0      in   requester 0 operands (signed, WIDTH bits)
//   a1,b1      in   requester 1 operands (signed, WIDTH bits)
//   ack0/ack1  out  one-cycle accept pulse, issued in the IDLE grant cycle
//   res0/res1  out  last product delivered to each requester (2*WIDTH bits)
//   vld0/vld1  out  one-cycle pulse: matching res was just updated
//   busy       out  FSM is not in IDLE
//   mul_start  out  start strobe to the multiplier
//   mul_x/y    out  multiplier operands, changed only in the grant cycle
//   mul_ready  in   multiplier idle flag
//   mul_done   in   one-cycle multiplier completion pulse
//   mul_p      in   multiplier product, valid with mul_done
// -----------------------------------------------------------------------------
module mult_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0,
    input  logic               req1,
    input  logic [WIDTH-1:0]   a0,
    input  logic [WIDTH-1:0]   b0,
    input  logic [WIDTH-1:0]   a1,
    input  logic [WIDTH-1:0]   b1,
    output logic               ack0,
    output logic               ack1,
    output logic [2*WIDTH-1:0] res0,
    output logic [2*WIDTH-1:0] res1,
    output logic               vld0,
    output logic               vld1,
    output logic               busy,
    output logic               mul_start,
    output logic [WIDTH-1:0]   mul_x,
    output logic [WIDTH-1:0]   mul_y,
    input  logic               mul_ready,
    input  logic               mul_done,
    input  logic [2*WIDTH-1:0] mul_p
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state, next_state;
    logic   owner;   // requester that owns the operation in flight
    logic   grant;   // a grant happens in this cycle
    logic   win;     // requester selected if grant is high

`ifdef MULT_ARB_RR_EN
    logic   last_win;   // requester granted most recently
`endif

    // Gating with rst keeps ack low while reset is held even though ack is
    // decoded combinationally from the request lines.
    assign grant = (state == IDLE) && mul_ready && (req0 || req1) && rst;
    assign busy  = (state != IDLE);

    always_comb begin
        win = 1'b0;
`ifdef MULT_ARB_RR_EN
        if (req0 && req1) begin
            win = ~last_win;
        end else begin
            win = req1;
        end
`else
        win = req1 && !req0;
`endif
    end

    // NOTE: the state register uses non-blocking assignments so every flop
    // samples pre-edge values; combinational blocks use blocking ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        ack0       = 1'b0;
        ack1       = 1'b0;
        mul_start  = 1'b0;
        vld0       = 1'b0;
        vld1       = 1'b0;
        case (state)
            IDLE: begin
                if (grant) begin
                    ack0       = ~win;
                    ack1       = win;
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                mul_start  = 1'b1;
                next_state = WAIT;
            end
            WAIT: begin
                if (mul_done) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                vld0       = ~owner;
                vld1       = owner;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Operand latch, ownership and result capture. mul_done outside WAIT is
    // deliberately ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_x    <= '0;
            mul_y    <= '0;
            owner    <= 1'b0;
            res0     <= '0;
            res1     <= '0;
`ifdef MULT_ARB_RR_EN
            last_win <= 1'b1;
`endif
        end else begin
            if (grant) begin
                mul_x    <= win ? a1 : a0;
                mul_y    <= win ? b1 : b0;
                owner    <= win;
`ifdef MULT_ARB_RR_EN
                last_win <= win;
`endif
            end
            if (state == WAIT && mul_done) begin
                if (owner) begin
                    res1 <= mul_p;
                end else begin
                    res0 <= mul_p;
                end
            end
        end
    end

endmodule
